ds_operand_ctrl: RTL and testbench

Parametrised decode-stage control block for the pipelined CPU. It holds the ID pipeline register (valid and payload) with the fs/ds/es handshake and selects each source operand from N forwarding stages, a long-latency writeback port, or the register file. It also stalls on not-yet-ready producers such as loads, and on a scoreboard of in-flight long-latency writes such as div/mod. It replaces the fixed two-source, three-stage bypass and load-use stall logic in the decode stage.

---
 rtl/ds_operand_ctrl.sv | 113 +++++++++++
 tb/tb_ds_operand_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_operand_ctrl.sv
// Decode-stage control: ID pipeline register, per-source operand forwarding and hazard stall.
// Define DS_SCOREBOARD_EN to add the pending-write scoreboard, lw_* forwarding and the WAW stall.
module ds_operand_ctrl #(
  parameter int NUM_FWD   = 3,
  parameter int NUM_SRC   = 2,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fs2ds_valid,
  input  logic [PAYLOAD_W-1:0]      fs2ds_payload,
  output logic                      ds_allowin,
  input  logic                      es_allowin,
  output logic                      ds2es_valid,
  output logic                      ds_valid,
  output logic [PAYLOAD_W-1:0]      ds_payload,
  input  logic                      flush,
  input  logic [NUM_SRC*5-1:0]      src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_SRC*DATA_W-1:0] rf_rdata,
  output logic [NUM_SRC*DATA_W-1:0] src_value,
  input  logic [4:0]                ds_dest,
  input  logic                      ds_gr_we,
  input  logic                      ds_long_op,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_ok,
  input  logic [NUM_FWD*5-1:0]      fwd_dest,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      lw_done,
  input  logic [4:0]                lw_addr,
  input  logic [DATA_W-1:0]         lw_data,
  output logic                      ready_go
);

  logic [31:0]        pending;
  logic [NUM_SRC-1:0] src_hazard;
  logic               waw;
  logic               lw_valid;

`ifdef DS_SCOREBOARD_EN
  logic [31:0] pending_nxt;
  logic        sb_set;

  assign lw_valid = lw_done;
  assign sb_set   = ds2es_valid & es_allowin & ds_long_op & ds_gr_we & (ds_dest != 5'd0);
  assign waw      = ds_gr_we & (ds_dest != 5'd0) & pending[ds_dest];

  // set is applied after clear so a same-cycle issue to the same register wins
  always_comb begin
    pending_nxt = pending;
    if (lw_done) pending_nxt[lw_addr] = 1'b0;
    if (sb_set)  pending_nxt[ds_dest] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end
`else
  logic unused_lw;

  assign lw_valid  = 1'b0;
  assign waw       = 1'b0;
  assign pending   = '0;
  assign unused_lw = &{1'b0, lw_done, ds_dest, ds_gr_we, ds_long_op};
`endif

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [4:0]        addr;
    logic              lw_hit;
    logic              fwd_hit;
    logic              fwd_rdy;
    logic [DATA_W-1:0] value;

    assign addr   = src_addr[i*5 +: 5];
    assign lw_hit = lw_valid & (lw_addr == addr) & (addr != 5'd0);

    // walk oldest to youngest so the youngest matching stage is the last writer
    always_comb begin
      fwd_hit = 1'b0;
      fwd_rdy = 1'b1;
      value   = lw_hit ? lw_data : rf_rdata[i*DATA_W +: DATA_W];
      for (int k = NUM_FWD-1; k >= 0; k--) begin
        if (fwd_valid[k] & fwd_we[k] & (fwd_dest[k*5 +: 5] == addr) & (addr != 5'd0)) begin
          fwd_hit = 1'b1;
          fwd_rdy = fwd_ok[k];
          value   = fwd_data[k*DATA_W +: DATA_W];
        end
      end
    end

    assign src_value[i*DATA_W +: DATA_W] = value;
    assign src_hazard[i] = src_used[i] & (fwd_hit ? ~fwd_rdy : (pending[addr] & ~lw_hit));
  end

  assign ready_go    = ~ds_valid | ~((|src_hazard) | waw);
  assign ds_allowin  = ~ds_valid | (ready_go & es_allowin);
  assign ds2es_valid = ds_valid & ready_go;

  always_ff @(posedge clk) begin
    if (reset | flush)   ds_valid <= 1'b0;
    else if (ds_allowin) ds_valid <= fs2ds_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)                           ds_payload <= '0;
    else if (fs2ds_valid & ds_allowin)   ds_payload <= fs2ds_payload;
  end

endmodule

// File: tb/tb_ds_operand_ctrl.sv
// Scoreboard bench for ds_operand_ctrl: directed hazard scenarios followed by random traffic.
module tb_ds_operand_ctrl;
  localparam int NUM_FWD   = 3;
  localparam int NUM_SRC   = 2;
  localparam int DATA_W    = 32;
  localparam int PAYLOAD_W = 64;
`ifdef DS_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      fs2ds_valid;
  logic [PAYLOAD_W-1:0]      fs2ds_payload;
  logic                      ds_allowin;
  logic                      es_allowin;
  logic                      ds2es_valid;
  logic                      ds_valid;
  logic [PAYLOAD_W-1:0]      ds_payload;
  logic                      flush;
  logic [NUM_SRC*5-1:0]      src_addr;
  logic [NUM_SRC-1:0]        src_used;
  logic [NUM_SRC*DATA_W-1:0] rf_rdata;
  logic [NUM_SRC*DATA_W-1:0] src_value;
  logic [4:0]                ds_dest;
  logic                      ds_gr_we;
  logic                      ds_long_op;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD-1:0]        fwd_ok;
  logic [NUM_FWD*5-1:0]      fwd_dest;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic                      lw_done;
  logic [4:0]                lw_addr;
  logic [DATA_W-1:0]         lw_data;
  logic                      ready_go;

  always #5 clk = ~clk;

  ds_operand_ctrl #(.NUM_FWD(NUM_FWD), .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .reset(reset), .fs2ds_valid(fs2ds_valid), .fs2ds_payload(fs2ds_payload),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds2es_valid(ds2es_valid),
    .ds_valid(ds_valid), .ds_payload(ds_payload), .flush(flush), .src_addr(src_addr),
    .src_used(src_used), .rf_rdata(rf_rdata), .src_value(src_value), .ds_dest(ds_dest),
    .ds_gr_we(ds_gr_we), .ds_long_op(ds_long_op), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
    .fwd_ok(fwd_ok), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .lw_done(lw_done),
    .lw_addr(lw_addr), .lw_data(lw_data), .ready_go(ready_go)
  );

  typedef struct packed {
    logic [NUM_SRC*DATA_W-1:0] value;
    logic                      rg;
    logic                      allowin;
    logic                      issue;
    logic                      valid;
    logic [PAYLOAD_W-1:0]      payload;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference state: an ID slot plus a set of registers awaiting long-latency results
  bit                   m_valid;
  logic [PAYLOAD_W-1:0] m_payload;
  bit                   m_pend[32];

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic clear_inputs();
    reset = 1'b0; fs2ds_valid = 1'b0; fs2ds_payload = '0; es_allowin = 1'b1; flush = 1'b0;
    src_addr = '0; src_used = '0; rf_rdata = {32'hAAAA_0001, 32'hAAAA_0000};
    ds_dest = '0; ds_gr_we = 1'b0; ds_long_op = 1'b0;
    fwd_valid = '0; fwd_we = '0; fwd_ok = '0; fwd_dest = '0; fwd_data = '0;
    lw_done = 1'b0; lw_addr = '0; lw_data = '0;
  endtask

  task automatic random_inputs();
    reset         = ($urandom_range(0, 99) == 0);
    fs2ds_valid   = 1'($urandom_range(0, 1));
    fs2ds_payload = {$urandom, $urandom};
    es_allowin    = ($urandom_range(0, 3) != 0);
    flush         = ($urandom_range(0, 9) == 0);
    for (int i = 0; i < NUM_SRC; i++) src_addr[i*5 +: 5] = 5'($urandom_range(0, 3));
    src_used      = NUM_SRC'($urandom);
    rf_rdata      = {$urandom, $urandom};
    ds_dest       = 5'($urandom_range(0, 3));
    ds_gr_we      = 1'($urandom_range(0, 1));
    ds_long_op    = 1'($urandom_range(0, 1));
    fwd_valid     = NUM_FWD'($urandom);
    fwd_we        = NUM_FWD'($urandom);
    fwd_ok        = NUM_FWD'($urandom);
    for (int k = 0; k < NUM_FWD; k++) fwd_dest[k*5 +: 5] = 5'($urandom_range(0, 3));
    fwd_data      = {$urandom, $urandom, $urandom};
    lw_done       = ($urandom_range(0, 3) == 0);
    lw_addr       = 5'($urandom_range(0, 3));
    lw_data       = $urandom;
  endtask

  // Predict this cycle's outputs from the reference state, queue them, advance the state, then clock.
  task automatic step();
    exp_t e;
    bit   haz, waw, rg, allowin, issue;
    haz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int                a;
      int                first;
      bit                lw_m;
      logic [DATA_W-1:0] v;
      a     = int'(src_addr[i*5 +: 5]);
      first = -1;
      lw_m  = SB_ON && lw_done && (int'(lw_addr) == a) && (a != 0);
      if (a != 0)
        for (int k = 0; k < NUM_FWD; k++)
          if (first < 0 && fwd_valid[k] && fwd_we[k] && int'(fwd_dest[k*5 +: 5]) == a) first = k;
      if (first >= 0) v = fwd_data[first*DATA_W +: DATA_W];
      else if (lw_m)  v = lw_data;
      else            v = rf_rdata[i*DATA_W +: DATA_W];
      e.value[i*DATA_W +: DATA_W] = v;
      if (src_used[i]) begin
        if (first >= 0) haz = haz || !fwd_ok[first];
        else            haz = haz || (m_pend[a] && !lw_m);
      end
    end
    waw     = SB_ON && ds_gr_we && (ds_dest != 0) && m_pend[ds_dest];
    rg      = !m_valid || !(haz || waw);
    allowin = !m_valid || (rg && es_allowin);
    issue   = m_valid && rg;
    e.rg = rg; e.allowin = allowin; e.issue = issue; e.valid = m_valid; e.payload = m_payload;
    exp_q.push_back(e);

    if (reset) begin
      m_valid = 1'b0;
      m_payload = '0;
      foreach (m_pend[r]) m_pend[r] = 1'b0;
    end else begin
      if (SB_ON) begin
        if (lw_done) m_pend[lw_addr] = 1'b0;
        if (issue && es_allowin && ds_long_op && ds_gr_we && ds_dest != 0) m_pend[ds_dest] = 1'b1;
      end
      if (fs2ds_valid && allowin) m_payload = fs2ds_payload;
      if (flush)        m_valid = 1'b0;
      else if (allowin) m_valid = fs2ds_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_id(input logic [PAYLOAD_W-1:0] p);
    clear_inputs();
    fs2ds_valid = 1'b1;
    fs2ds_payload = p;
    step();
  endtask

  // monitor: outputs are presented every cycle; compare mid-cycle against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("src_value",   128'(src_value),   128'(e.value));
        check("ready_go",    128'(ready_go),    128'(e.rg));
        check("ds_allowin",  128'(ds_allowin),  128'(e.allowin));
        check("ds2es_valid", 128'(ds2es_valid), 128'(e.issue));
        check("ds_valid",    128'(ds_valid),    128'(e.valid));
        check("ds_payload",  128'(ds_payload),  128'(e.payload));
      end
    end
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    m_valid = 1'b0;
    m_payload = '0;
    foreach (m_pend[r]) m_pend[r] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_inputs();

    // reset state
    step();

    // forwarding priority: stage 0 beats stage 2
    load_id(64'h1000_0000_0000_0001);
    clear_inputs();
    src_addr = {5'd0, 5'd5}; src_used = 2'b01;
    fwd_valid = 3'b101; fwd_we = 3'b101; fwd_ok = 3'b101;
    fwd_dest = {5'd5, 5'd0, 5'd5}; fwd_data = {32'h22, 32'h0, 32'h11};
    step();

    // load-use: one stall cycle, then forward from stage 1
    load_id(64'h1000_0004_0000_0002);
    clear_inputs();
    src_addr = {5'd0, 5'd7}; src_used = 2'b01;
    fwd_valid = 3'b001; fwd_we = 3'b001; fwd_ok = 3'b000; fwd_dest = {5'd0, 5'd0, 5'd7};
    fs2ds_valid = 1'b1; fs2ds_payload = 64'hDEAD_DEAD_DEAD_DEAD;
    step();
    clear_inputs();
    src_addr = {5'd0, 5'd7}; src_used = 2'b01;
    fwd_valid = 3'b010; fwd_we = 3'b010; fwd_ok = 3'b010; fwd_dest = {5'd0, 5'd7, 5'd0};
    fwd_data = {32'h0, 32'h77, 32'h0};
    step();

    // r0 never forwards; an unused source never stalls
    load_id(64'h1000_0008_0000_0003);
    clear_inputs();
    src_addr = {5'd3, 5'd0}; src_used = 2'b01;
    fwd_valid = 3'b011; fwd_we = 3'b011; fwd_ok = 3'b000;
    fwd_dest = {5'd0, 5'd3, 5'd0}; fwd_data = {32'h0, 32'h33, 32'h99};
    step();

    // flush beats a simultaneous load
    clear_inputs();
    fs2ds_valid = 1'b1; fs2ds_payload = 64'h1000_000C_0000_0004; flush = 1'b1;
    step();
    clear_inputs();
    step();

    // div to r9 issues, dependent waits for lw_done
    load_id(64'h1000_0010_0000_0005);
    clear_inputs();
    ds_long_op = 1'b1; ds_gr_we = 1'b1; ds_dest = 5'd9;
    fs2ds_valid = 1'b1; fs2ds_payload = 64'h1000_0014_0000_0006;
    step();
    clear_inputs();
    src_addr = {5'd0, 5'd9}; src_used = 2'b01;
    step();
    step();
    lw_done = 1'b1; lw_addr = 5'd9; lw_data = 32'h55;
    step();

    // set and clear of r9 in the same cycle: set wins
    load_id(64'h1000_0018_0000_0007);
    clear_inputs();
    ds_long_op = 1'b1; ds_gr_we = 1'b1; ds_dest = 5'd9;
    lw_done = 1'b1; lw_addr = 5'd9; lw_data = 32'h66;
    fs2ds_valid = 1'b1; fs2ds_payload = 64'h1000_001C_0000_0008;
    step();
    clear_inputs();
    src_addr = {5'd0, 5'd9}; src_used = 2'b01;
    step();

    // reset mid-stall clears the ID slot and the scoreboard
    reset = 1'b1;
    step();
    load_id(64'h1000_0020_0000_0009);
    clear_inputs();
    src_addr = {5'd0, 5'd9}; src_used = 2'b01;
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      random_inputs();
      step();
    end
    clear_inputs();

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
